shift_seq: RTL

Parametrised, iterative shift/rotate unit for the ALU datapath. Generalises the fixed by-8 shift stage to any power-of-two width and any shift amount: one log2 stage is applied per clock, under valid/ready handshakes on both sides. It sits between operand decode and ALU writeback and is used for multi-cycle shift instructions.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_stage.sv | 25 ++
 rtl/shift_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift/rotate unit: op encodings and FSM states.
package shift_pkg;

  localparam logic [1:0] SH_ROL = 2'b00;
  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_SRL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } shift_state_t;

  // Stage counter width; never narrower than one bit.
  function automatic int counter_width(input int shw);
    return (shw > 1) ? $clog2(shw) : 1;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// Combinational by-DIST shift/rotate stage; one instance per power-of-two distance.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = d;
    case (op)
      SH_ROL:  q = {d[WIDTH-DIST-1:0], d[WIDTH-1:WIDTH-DIST]};
      SH_SLL:  q = {d[WIDTH-DIST-1:0], {DIST{1'b0}}};
      SH_SRA:  q = {{DIST{sign}}, d[WIDTH-1:DIST]};
      SH_SRL:  q = {{DIST{1'b0}}, d[WIDTH-1:DIST]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Iterative shift/rotate: applies one log2 stage per clock under valid/ready handshakes.
// Optional out_carry port and logic are built only when SHIFT_SEQ_CARRY_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high (after reset has cleared)
// BUSY  | stepping through stages k = 0..SHW-1
// DONE  | result held on out_data with out_valid high until out_ready
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [SHW-1:0]   in_amt,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFT_SEQ_CARRY_EN
  output logic             out_carry,
`endif
  output logic [WIDTH-1:0] out_data
);

  localparam int KW = counter_width(SHW);
  localparam logic [KW-1:0] K_LAST = KW'(SHW - 1);

  shift_state_t     state, state_nx;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] res;
  logic [1:0]       op_q;
  logic [SHW-1:0]   amt_q;
  logic             sign_q;
  logic             rdy_q;
  logic             accept;
  logic [WIDTH-1:0] stage_q [SHW];
  logic [WIDTH-1:0] stage_sel;
  logic             amt_bit;

  assign accept = in_valid & rdy_q;

  for (genvar g = 0; g < SHW; g++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << g)
    ) u_stage (
      .d    (res),
      .op   (op_q),
      .sign (sign_q),
      .q    (stage_q[g])
    );
  end

  always_comb begin
    stage_sel = res;
    amt_bit   = 1'b0;
    for (int i = 0; i < SHW; i++) begin
      if (k == KW'(i)) begin
        stage_sel = stage_q[i];
        amt_bit   = amt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (k == K_LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rdy_q;
    out_valid = (state == DONE);
  end

  // Registered ready keeps in_ready low throughout reset without a path from rst.
  always_ff @(posedge clk) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= (state_nx == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res    <= '0;
      k      <= '0;
      op_q   <= SH_ROL;
      amt_q  <= '0;
      sign_q <= 1'b0;
    end else if (accept) begin
      res    <= in_data;
      op_q   <= in_op;
      amt_q  <= in_amt;
      sign_q <= in_data[WIDTH-1];
      k      <= '0;
    end else if (state == BUSY) begin
      if (amt_bit) res <= stage_sel;
      k <= k + KW'(1);
    end
  end

  assign out_data = res;

`ifdef SHIFT_SEQ_CARRY_EN
  logic             carry_q;
  logic             carry_nx;
  logic [SHW-1:0]   amt_m1;
  logic [WIDTH-1:0] left_t;
  logic [WIDTH-1:0] right_t;

  // Last bit out is known at accept: d[WIDTH-n] for left moves, d[n-1] for right moves.
  always_comb begin
    amt_m1   = in_amt - SHW'(1);
    left_t   = in_data << amt_m1;
    right_t  = in_data >> amt_m1;
    carry_nx = 1'b0;
    if (in_amt != '0) begin
      if (in_op == SH_ROL || in_op == SH_SLL) carry_nx = left_t[WIDTH-1];
      else                                    carry_nx = right_t[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         carry_q <= 1'b0;
    else if (accept) carry_q <= carry_nx;
  end

  assign out_carry = carry_q;
`endif

endmodule
